// File: rtl/key_pkg.sv
// Shared types and defaults for the key event arbiter and its per-key timers.
package key_pkg;

  localparam int unsigned N_KEYS_DEF   = 4;
  localparam int unsigned LONG_CNT_DEF = 50_000_000;

  typedef enum logic [1:0] {
    KEY_IDLE   = 2'd0,
    KEY_TIMING = 2'd1,
    KEY_HELD   = 2'd2
  } key_state_e;

  // Event record; key is sized for the largest supported bank (16 keys).
  typedef struct packed {
    logic [3:0] key;
    logic       is_long;
  } key_evt_t;

endpackage

// File: rtl/key_press_timer.sv
// One key channel: input register, press FSM, hold counter and one-entry pending slot.
module key_press_timer
  import key_pkg::*;
#(
  parameter int unsigned LONG_CNT = LONG_CNT_DEF,
  parameter int unsigned CNT_W    = 26
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  input  logic clr_i,
  output logic pend_o,
  output logic pend_long_o,
  output logic drop_o
);

  // Compared against the pre-edge count, so the long event posts on the edge the count reaches LONG_CNT-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LONG_CNT - 2);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q;
  logic             pend_q, pend_d;
  logic             pend_long_q, pend_long_d;
  logic             post, post_long;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    post      = 1'b0;
    post_long = 1'b0;
    case (state_q)
      KEY_IDLE: begin
        cnt_d = '0;
        if (key_q && !key_i) state_d = KEY_TIMING;
      end
      KEY_TIMING: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          post      = 1'b1;
          post_long = 1'b1;
          if (key_i) begin
            state_d = KEY_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = KEY_HELD;
          end
        end else if (key_i) begin
          post    = 1'b1;
          state_d = KEY_IDLE;
          cnt_d   = '0;
        end
      end
      KEY_HELD: begin
        if (key_i) begin
          state_d = KEY_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = KEY_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbiter clear is applied before the new post, so clear+post refills without a drop.
  always_comb begin
    pend_d      = pend_q & ~clr_i;
    pend_long_d = pend_long_q;
    drop_o      = 1'b0;
    if (post) begin
      if (pend_d) begin
        drop_o = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_long_d = post_long;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= KEY_IDLE;
      cnt_q       <= '0;
      key_q       <= 1'b1;
      pend_q      <= 1'b0;
      pend_long_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_i;
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
    end
  end

  assign pend_o      = pend_q;
  assign pend_long_o = pend_long_q;

endmodule

// File: rtl/key_event_arbiter.sv
// Key bank front end: per-key press timers feeding a round-robin arbiter and a valid/ready event register.
module key_event_arbiter
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS   = N_KEYS_DEF,
  parameter int unsigned LONG_CNT = LONG_CNT_DEF,
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned KEY_W    = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [N_KEYS-1:0] Key_In,
  output logic              Evt_Valid,
  input  logic              Evt_Ready,
  output logic [KEY_W-1:0]  Evt_Key,
  output logic              Evt_Long,
  output logic              Evt_Overrun,
  input  logic              Ovr_Clr
);

  localparam logic [KEY_W:0] NK = (KEY_W + 1)'(N_KEYS);

  logic [N_KEYS-1:0] pend, pend_long, drop, clr;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_press_timer #(
      .LONG_CNT (LONG_CNT),
      .CNT_W    (CNT_W)
    ) u_timer (
      .clk_i       (CLK),
      .rst_ni      (RSTn),
      .key_i       (Key_In[g]),
      .clr_i       (clr[g]),
      .pend_o      (pend[g]),
      .pend_long_o (pend_long[g]),
      .drop_o      (drop[g])
    );
  end

  logic             valid_q, valid_d;
  logic [KEY_W-1:0] evt_key_q, evt_key_d;
  logic             evt_long_q, evt_long_d;
  logic             ovr_q, ovr_d;
  logic [KEY_W-1:0] rr_q, rr_d;

  logic [N_KEYS-1:0] rot;
  logic              found;
  logic [KEY_W-1:0]  off, grant;
  logic [KEY_W:0]    sum, nxt;

  // Rotate pending so bit 0 is rr_ptr; the first set bit is the offset of the grant.
  always_comb begin
    rot   = N_KEYS'({pend, pend} >> rr_q);
    found = 1'b0;
    off   = '0;
    for (int unsigned j = 0; j < N_KEYS; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = KEY_W'(j);
      end
    end
    sum = {1'b0, rr_q} + {1'b0, off};
    if (sum >= NK) sum = sum - NK;
    grant = sum[KEY_W-1:0];
    nxt   = {1'b0, grant} + 1'b1;
  end

  always_comb begin
    valid_d    = valid_q;
    evt_key_d  = evt_key_q;
    evt_long_d = evt_long_q;
    rr_d       = rr_q;
    clr        = '0;
    if (!valid_q || Evt_Ready) begin
      valid_d = found;
      if (found) begin
        evt_key_d   = grant;
        evt_long_d  = pend_long[grant];
        clr[grant]  = 1'b1;
        rr_d        = (nxt == NK) ? '0 : nxt[KEY_W-1:0];
      end
    end
    ovr_d = (ovr_q & ~Ovr_Clr) | (|drop);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_q    <= 1'b0;
      evt_key_q  <= '0;
      evt_long_q <= 1'b0;
      ovr_q      <= 1'b0;
      rr_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      evt_key_q  <= evt_key_d;
      evt_long_q <= evt_long_d;
      ovr_q      <= ovr_d;
      rr_q       <= rr_d;
    end
  end

  assign Evt_Valid   = valid_q;
  assign Evt_Key     = evt_key_q;
  assign Evt_Long    = evt_long_q;
  assign Evt_Overrun = ovr_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter with N_KEYS=4, LONG_CNT=10.
module tb_key_event_arbiter;
  import key_pkg::*;

  logic       clk;
  logic       RSTn;
  logic [3:0] Key_In;
  logic       Evt_Valid;
  logic       Evt_Ready;
  logic [1:0] Evt_Key;
  logic       Evt_Long;
  logic       Evt_Overrun;
  logic       Ovr_Clr;

  int n_cmp = 0;
  int n_err = 0;
  key_evt_t exp_q[$];

  key_event_arbiter #(
    .N_KEYS   (4),
    .LONG_CNT (10),
    .CNT_W    (4),
    .KEY_W    (2)
  ) dut (
    .CLK         (clk),
    .RSTn        (RSTn),
    .Key_In      (Key_In),
    .Evt_Valid   (Evt_Valid),
    .Evt_Ready   (Evt_Ready),
    .Evt_Key     (Evt_Key),
    .Evt_Long    (Evt_Long),
    .Evt_Overrun (Evt_Overrun),
    .Ovr_Clr     (Ovr_Clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic lng);
    key_evt_t e;
    e.key     = 4'(k);
    e.is_long = lng;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented event must match the scoreboard head; pop on acceptance.
  always @(negedge clk) begin
    if (RSTn && Evt_Valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got key=%0d long=%0b, expected no event", Evt_Key, Evt_Long);
      end else begin
        check("evt_key", 32'(Evt_Key), 32'(exp_q[0].key));
        check("evt_long", 32'(Evt_Long), 32'(exp_q[0].is_long));
        if (Evt_Ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn      = 1'b1;
    Key_In    = '1;
    Evt_Ready = 1'b0;
    Ovr_Clr   = 1'b0;
    #1 RSTn = 1'b0;
    #2;
    check("rst_valid", 32'(Evt_Valid), 0);
    check("rst_key", 32'(Evt_Key), 0);
    check("rst_long", 32'(Evt_Long), 0);
    check("rst_ovr", 32'(Evt_Overrun), 0);
    @(posedge clk); #1 RSTn = 1'b1;
    tick();

    // Round-robin: keys 0,1,3 release together, stalled for 5 cycles.
    Key_In = 4'b0100;
    repeat (3) tick();
    Key_In = 4'b1111;
    push(0, 0); push(1, 0); push(3, 0);
    tick();
    check("rr_valid_early", 32'(Evt_Valid), 0);
    tick();
    check("rr_valid_first", 32'(Evt_Valid), 1);
    repeat (5) tick();
    check("rr_stall_key", 32'(Evt_Key), 0);
    Evt_Ready = 1'b1;
    tick();
    check("rr_second_valid", 32'(Evt_Valid), 1);
    check("rr_second_key", 32'(Evt_Key), 1);
    tick();
    check("rr_third_valid", 32'(Evt_Valid), 1);
    check("rr_third_key", 32'(Evt_Key), 3);
    tick();
    check("rr_drained", 32'(Evt_Valid), 0);
    Key_In = 4'b0110;
    repeat (3) tick();
    Key_In = 4'b1111;
    push(0, 0); push(3, 0);
    repeat (5) tick();

    // Short press on key 2 for 5 cycles.
    Key_In[2] = 1'b0;
    repeat (5) tick();
    Key_In[2] = 1'b1;
    push(2, 0);
    tick();
    check("short_valid_early", 32'(Evt_Valid), 0);
    tick();
    check("short_latency", 32'(Evt_Valid), 1);
    tick();
    check("short_done", 32'(Evt_Valid), 0);
    repeat (2) tick();

    // Long press on key 1, held 30 cycles.
    Key_In[1] = 1'b0;
    push(1, 1);
    repeat (10) tick();
    check("long_valid_early", 32'(Evt_Valid), 0);
    tick();
    check("long_latency", 32'(Evt_Valid), 1);
    repeat (19) tick();
    Key_In[1] = 1'b1;
    repeat (5) tick();

    // Boundary: 9 held cycles is long, 8 is short.
    Key_In[2] = 1'b0;
    repeat (9) tick();
    Key_In[2] = 1'b1;
    push(2, 1);
    repeat (4) tick();
    Key_In[2] = 1'b0;
    repeat (8) tick();
    Key_In[2] = 1'b1;
    push(2, 0);
    repeat (4) tick();

    // Overrun: three short presses on key 0 while stalled.
    Evt_Ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      Key_In[0] = 1'b0;
      repeat (2) tick();
      Key_In[0] = 1'b1;
      if (n < 2) push(0, 0);
      tick();
      check("ovr_flag", 32'(Evt_Overrun), (n == 2) ? 1 : 0);
      tick();
    end
    repeat (2) tick();
    check("ovr_sticky", 32'(Evt_Overrun), 1);
    Ovr_Clr = 1'b1;
    tick();
    Ovr_Clr = 1'b0;
    check("ovr_clear", 32'(Evt_Overrun), 0);
    Evt_Ready = 1'b1;
    repeat (4) tick();

    // Reset mid-operation with an event presented and key 3 held.
    Evt_Ready = 1'b0;
    Key_In[0] = 1'b0;
    repeat (2) tick();
    Key_In[0] = 1'b1;
    push(0, 0);
    repeat (2) tick();
    check("pre_rst_valid", 32'(Evt_Valid), 1);
    Key_In[3] = 1'b0;
    repeat (3) tick();
    #2 RSTn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(Evt_Valid), 0);
    check("mid_rst_key", 32'(Evt_Key), 0);
    check("mid_rst_long", 32'(Evt_Long), 0);
    check("mid_rst_ovr", 32'(Evt_Overrun), 0);
    exp_q.delete();
    @(posedge clk); #1 RSTn = 1'b1;
    push(3, 1);
    Evt_Ready = 1'b1;
    repeat (10) tick();
    check("rst_long_early", 32'(Evt_Valid), 0);
    tick();
    check("rst_long_latency", 32'(Evt_Valid), 1);
    Key_In[3] = 1'b1;
    repeat (4) tick();

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
# key_event_arbiter

Controller that sits behind a bank of debounced key channels (one per key-detect/delay pair) and turns their levels into a single stream of key events. Each key's press is timed and classified as a short press (reported on release) or a long press (reported once the hold threshold is reached). Pending events from all keys are shared onto one valid/ready output port by a round-robin arbiter, for consumption by the display/menu logic downstream.

## Interface
- N_KEYS, 4: number of key channels, range 2..16.
- LONG_CNT, 50_000_000: hold cycles that make a press long (1 s at 50 MHz); minimum 2.
- CNT_W, 26: hold-counter width; must satisfy 2^CNT_W > LONG_CNT.
- KEY_W, 2: event key-index width, equal to clog2(N_KEYS).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- Key_In  in  N_KEYS  debounced key levels, same clock domain; 0 = pressed, 1 = released.
- Evt_Valid  out  1  an event is presented.
- Evt_Ready  in  1  consumer accepts the event when Evt_Valid=1 and Evt_Ready=1 at a clock edge.
- Evt_Key  out  KEY_W  index of the reporting key.
- Evt_Long  out  1  1 = long press, 0 = short press.
- Evt_Overrun  out  1  sticky flag: an event was dropped.
- Ovr_Clr  in  1  synchronous clear of Evt_Overrun.

## Operation
- Key_In is registered once into Key_q. Key_q resets to all 1s, so a key held through reset reads as a fresh press on the first active edge.
- Each key has its own 3-state FSM and a CNT_W counter:
  - IDLE: counter 0. On a press edge (Key_q=1, Key_In=0), go to TIMING.
  - TIMING: counter increments each cycle.
    - Release before the counter reaches LONG_CNT-1 posts a short event and returns to IDLE.
    - Reaching LONG_CNT-1 while still held posts a long event and goes to HELD.
  - HELD: counter frozen. Release returns to IDLE with no event.
- Each key has a one-entry pending slot (pend, pend_long).
  - Posting while the slot is full drops the new event and sets Evt_Overrun.
  - The pending event is kept unchanged.
- Output register (Evt_Valid/Evt_Key/Evt_Long):
  - Loads when empty, or in the same cycle it is consumed.
  - The source key is the first pending slot at or after rr_ptr, in ascending index order with wrap-around.
  - Loading clears that key's pending slot; rr_ptr becomes granted index + 1, mod N_KEYS.
- While Evt_Valid=1 and Evt_Ready=0, Evt_Key and Evt_Long hold stable.
- A post and a clear to the same slot in one cycle: the clear wins first, then the post fills the slot. No overrun results.
- Evt_Overrun:
  - Stays set until Ovr_Clr=1.
  - If Ovr_Clr and a new drop happen in the same cycle, the flag stays 1.

## Timing
- Reset values: Evt_Valid=0, Evt_Key=0, Evt_Long=0, Evt_Overrun=0, rr_ptr=0, all FSMs in IDLE, counters 0, pending slots empty.
- Press or release: Key_In changes before edge t and the FSM transitions at edge t. The pending slot sets at t. Evt_Valid rises at t+1 if the output register is free, giving 2 cycles from input change to Evt_Valid.
- Long press: pressed at edge t, the long event is posted at edge t+LONG_CNT-1.
- Back-to-back accept: with Evt_Ready held at 1 and k keys pending, one event is delivered per cycle with no bubble.
- Reset asserted mid-operation clears everything immediately, including a presented event that has not been accepted; that event is lost.

## Structure
- Shared package key_pkg:
  - FSM state enum (KEY_IDLE, KEY_TIMING, KEY_HELD).
  - Default constants for N_KEYS and LONG_CNT.
  - The event record type {key, long}.
- Sub-module key_press_timer:
  - Contains one key's Key_q, FSM, counter and pending slot.
  - Instantiated N_KEYS times with a generate loop.
  - Outputs pend/pend_long; takes a clear input from the arbiter.
- The top level holds the round-robin arbiter, the output register and the overrun logic.

## Test plan
All scenarios use N_KEYS=4, LONG_CNT=10.
- Short press: key 2 pressed for 5 cycles, then released; Evt_Ready=1 → one event Key=2, Long=0, with Evt_Valid rising 2 cycles after the release.
- Long press: key 1 held for 30 cycles → one event Key=1, Long=1, with Evt_Valid rising 10 cycles after the press; no event on release.
- Round-robin order: keys 0, 1, 3 release in the same cycle; Evt_Ready=0 for 5 cycles, then 1 → outputs hold Key=0 stable while stalled, then Key=1 and Key=3 follow on consecutive cycles. Then a new key 0 and key 3 pair of events → key 0 first, since rr_ptr=0 after the wrap.
- Overrun: key 0 makes 3 short presses while Evt_Ready=0 → the first event is presented, the second sits pending, the third is dropped and Evt_Overrun=1. Ovr_Clr pulse → Evt_Overrun=0.
- Reset mid-operation: RSTn low while Evt_Valid=1 and key 3 is held → all outputs 0 immediately. After release with key 3 still held, a long event for key 3 arrives LONG_CNT cycles later.
- Boundary: key held exactly 9 cycles → long event. Held 8 cycles → short event.
